dsdaccel_fmap_packer: RTL and testbench

- Write-side counterpart of the unaligned image-ROM reader.
- Accepts a stream of 16-byte beats destined for an arbitrary byte address. Packs them into aligned 128-bit words and issues byte-masked writes to a 128-bit-wide feature-map RAM.
- Sits between the compute pipeline's byte output and the RAM write port. Lets the pipeline emit at full rate without aligning its own writes.

---
 rtl/dsdaccel_fmap_packer.sv | 144 ++++++++++++++
 tb/tb_dsdaccel_fmap_packer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsdaccel_fmap_packer.sv
// Packs a byte stream that starts at any byte address into aligned 128-bit words
// and emits one byte-masked RAM write per word, with a trailing flush write if needed.
module dsdaccel_fmap_packer #(
   parameter int IAW = 8
) (
   input  logic             i_CLK,
   input  logic             i_RST,
   input  logic             i_START,
   input  logic [IAW+3:0]   i_BASE_ADDR,
   input  logic             i_VALID,
   output logic             o_READY,
   input  logic [7:0]       i_DIN [0:15],
   input  logic             i_LAST,
   input  logic [4:0]       i_NBYTES,
   output logic             o_WE,
   output logic [IAW-1:0]   o_WADDR,
   output logic [127:0]     o_WDATA,
   output logic [15:0]      o_WBE,
   output logic             o_BUSY,
   output logic             o_DONE
);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

   state_t           r_state;
   logic [3:0]       r_off;
   logic [IAW-1:0]   r_waddr;
   logic             r_first;
   logic [7:0]       r_resid [0:15];
   logic [4:0]       r_flush_n;

   logic             w_accept;
   logic [4:0]       w_n;
   logic [5:0]       w_end;
   logic [3:0]       w_idx;
   logic             w_lo;
   logic [127:0]     w_cur_data;
   logic [15:0]      w_cur_be;
   logic [7:0]       w_nxt [0:15];
   logic [127:0]     w_flush_data;
   logic [15:0]      w_flush_be;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_accept     = (r_state == S_STREAM) && i_VALID && o_READY;
      w_n          = (i_NBYTES == 5'd0) ? 5'd16 : i_NBYTES;
      w_end        = {2'b00, r_off} + {1'b0, w_n};
      w_idx        = 4'd0;
      w_lo         = 1'b0;
      w_cur_data   = '0;
      w_cur_be     = '0;
      w_flush_data = '0;
      w_flush_be   = '0;
      for (int k = 0; k < 16; k++) begin
         w_nxt[k] = 8'h00;
      end
      // Byte k of the current word and byte k of the next word share one beat index, (k - off) mod 16.
      for (int k = 0; k < 16; k++) begin
         w_idx = 4'(k) - r_off;
         w_lo  = (4'(k) < r_off);
         w_cur_data[(15-k)*8 +: 8] = w_lo ? r_resid[k] : i_DIN[w_idx];
         w_nxt[k]                  = w_lo ? i_DIN[w_idx] : 8'h00;
         w_cur_be[15-k]            = !(r_first && w_lo) && (!i_LAST || (6'(k) < w_end));
         w_flush_data[(15-k)*8 +: 8] = r_resid[k];
         w_flush_be[15-k]            = (5'(k) < r_flush_n);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_state   <= S_IDLE;
         r_off     <= '0;
         r_waddr   <= '0;
         r_first   <= 1'b0;
         r_flush_n <= '0;
         // NOTE: the residual is a small register bank, not a RAM, so it is cleared on reset like any flop.
         for (int k = 0; k < 16; k++) begin
            r_resid[k] <= 8'h00;
         end
         o_READY   <= 1'b0;
         o_WE      <= 1'b0;
         o_WADDR   <= '0;
         o_WDATA   <= '0;
         o_WBE     <= '0;
         o_BUSY    <= 1'b0;
         o_DONE    <= 1'b0;
      end else begin
         o_WE   <= 1'b0;
         o_DONE <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_START) begin
                  r_off   <= i_BASE_ADDR[3:0];
                  r_waddr <= i_BASE_ADDR[IAW+3:4];
                  r_first <= 1'b1;
                  r_state <= S_STREAM;
                  o_READY <= 1'b1;
                  o_BUSY  <= 1'b1;
               end
            end
            S_STREAM: begin
               if (w_accept) begin
                  o_WE    <= 1'b1;
                  o_WADDR <= r_waddr;
                  o_WDATA <= w_cur_data;
                  o_WBE   <= w_cur_be;
                  for (int k = 0; k < 16; k++) begin
                     r_resid[k] <= w_nxt[k];
                  end
                  r_waddr <= r_waddr + 1'b1;
                  r_first <= 1'b0;
                  if (i_LAST) begin
                     o_READY <= 1'b0;
                     if (w_end > 6'd16) begin
                        r_flush_n <= 5'(w_end - 6'd16);
                        r_state   <= S_FLUSH;
                     end else begin
                        o_DONE  <= 1'b1;
                        o_BUSY  <= 1'b0;
                        r_state <= S_IDLE;
                     end
                  end
               end
            end
            S_FLUSH: begin
               o_WE    <= 1'b1;
               o_WADDR <= r_waddr;
               o_WDATA <= w_flush_data;
               o_WBE   <= w_flush_be;
               o_DONE  <= 1'b1;
               o_BUSY  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               o_READY <= 1'b0;
               o_BUSY  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dsdaccel_fmap_packer.sv
// Directed bench for dsdaccel_fmap_packer: captures every RAM write and compares
// it against hand-computed address, byte enables, enabled data lanes and done flag.
module tb_dsdaccel_fmap_packer;

   localparam int IAW = 8;

   logic             clk = 1'b0;
   logic             i_RST;
   logic             i_START;
   logic [IAW+3:0]   i_BASE_ADDR;
   logic             i_VALID;
   logic             o_READY;
   logic [7:0]       din [0:15];
   logic             i_LAST;
   logic [4:0]       i_NBYTES;
   logic             o_WE;
   logic [IAW-1:0]   o_WADDR;
   logic [127:0]     o_WDATA;
   logic [15:0]      o_WBE;
   logic             o_BUSY;
   logic             o_DONE;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [IAW-1:0] a;
      logic [127:0]   d;
      logic [15:0]    be;
      logic           dn;
   } wr_t;

   wr_t wq[$];

   dsdaccel_fmap_packer #(.IAW(IAW)) dut (
      .i_CLK       (clk),
      .i_RST       (i_RST),
      .i_START     (i_START),
      .i_BASE_ADDR (i_BASE_ADDR),
      .i_VALID     (i_VALID),
      .o_READY     (o_READY),
      .i_DIN       (din),
      .i_LAST      (i_LAST),
      .i_NBYTES    (i_NBYTES),
      .o_WE        (o_WE),
      .o_WADDR     (o_WADDR),
      .o_WDATA     (o_WDATA),
      .o_WBE       (o_WBE),
      .o_BUSY      (o_BUSY),
      .o_DONE      (o_DONE)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_WE === 1'b1) begin
         wq.push_back('{a: o_WADDR, d: o_WDATA, be: o_WBE, dn: o_DONE});
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] bytes_at(input int pos, input logic [7:0] v0, input int cnt);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < cnt; i++) begin
         r[(15-(pos+i))*8 +: 8] = v0 + 8'(i);
      end
      return r;
   endfunction

   function automatic logic [127:0] be_mask(input logic [15:0] be);
      logic [127:0] m;
      for (int b = 0; b < 16; b++) begin
         m[b*8 +: 8] = {8{be[b]}};
      end
      return m;
   endfunction

   task automatic chk_wr(input string tag, input int i, input logic [IAW-1:0] a,
                         input logic [15:0] be, input logic [127:0] d, input logic dn);
      if (i >= wq.size()) begin
         check({tag, "_count"}, 128'(wq.size()), 128'(i + 1));
         return;
      end
      check({tag, "_addr"}, 128'(wq[i].a), 128'(a));
      check({tag, "_be"},   128'(wq[i].be), 128'(be));
      check({tag, "_data"}, wq[i].d & be_mask(be), d & be_mask(be));
      check({tag, "_done"}, 128'(wq[i].dn), 128'(dn));
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input logic [IAW+3:0] base);
      i_START     = 1'b1;
      i_BASE_ADDR = base;
      tick(1);
      i_START     = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] b0, input logic last, input logic [4:0] n);
      int guard;
      for (int i = 0; i < 16; i++) din[i] = b0 + 8'(i);
      i_VALID  = 1'b1;
      i_LAST   = last;
      i_NBYTES = n;
      guard    = 0;
      while (o_READY !== 1'b1 && guard < 20) begin
         tick(1);
         guard++;
      end
      if (guard >= 20) check("ready_timeout", 128'(o_READY), 128'(1));
      tick(1);
      i_VALID  = 1'b0;
      i_LAST   = 1'b0;
      i_NBYTES = 5'd0;
   endtask

   initial begin
      i_RST       = 1'b1;
      i_START     = 1'b0;
      i_BASE_ADDR = '0;
      i_VALID     = 1'b0;
      i_LAST      = 1'b0;
      i_NBYTES    = 5'd0;
      for (int i = 0; i < 16; i++) din[i] = 8'h00;
      tick(2);
      check("rst_ready", 128'(o_READY), 128'(0));
      check("rst_we",    128'(o_WE),    128'(0));
      check("rst_done",  128'(o_DONE),  128'(0));
      check("rst_busy",  128'(o_BUSY),  128'(0));
      check("rst_waddr", 128'(o_WADDR), 128'(0));
      check("rst_wdata", o_WDATA,       128'(0));
      check("rst_wbe",   128'(o_WBE),   128'(0));
      i_RST = 1'b0;
      tick(1);

      // Aligned, three full beats
      wq.delete();
      do_start(12'h040);
      check("al_busy", 128'(o_BUSY), 128'(1));
      send_beat(8'h00, 1'b0, 5'd0);
      send_beat(8'h10, 1'b0, 5'd0);
      send_beat(8'h20, 1'b1, 5'd16);
      tick(4);
      check("al_nwr", 128'(wq.size()), 128'(3));
      chk_wr("al0", 0, 8'h04, 16'hFFFF, bytes_at(0, 8'h00, 16), 1'b0);
      chk_wr("al1", 1, 8'h05, 16'hFFFF, bytes_at(0, 8'h10, 16), 1'b0);
      chk_wr("al2", 2, 8'h06, 16'hFFFF, bytes_at(0, 8'h20, 16), 1'b1);
      check("al_idle_busy", 128'(o_BUSY), 128'(0));

      // Unaligned base 5 with flush
      wq.delete();
      do_start(12'h005);
      send_beat(8'h00, 1'b0, 5'd0);
      send_beat(8'h10, 1'b1, 5'd16);
      check("ua_flush_ready", 128'(o_READY), 128'(0));
      check("ua_flush_busy",  128'(o_BUSY),  128'(1));
      tick(4);
      check("ua_nwr", 128'(wq.size()), 128'(3));
      chk_wr("ua0", 0, 8'h00, 16'h07FF, bytes_at(5, 8'h00, 11), 1'b0);
      chk_wr("ua1", 1, 8'h01, 16'hFFFF, bytes_at(0, 8'h0B, 16), 1'b0);
      chk_wr("ua2", 2, 8'h02, 16'hF800, bytes_at(0, 8'h1B, 5),  1'b1);
      check("ua_idle_busy", 128'(o_BUSY), 128'(0));

      // Short tail crossing a word boundary
      wq.delete();
      do_start(12'h00C);
      send_beat(8'hA0, 1'b1, 5'd8);
      tick(4);
      check("st_nwr", 128'(wq.size()), 128'(2));
      chk_wr("st0", 0, 8'h00, 16'h000F, bytes_at(12, 8'hA0, 4), 1'b0);
      chk_wr("st1", 1, 8'h01, 16'hF000, bytes_at(0, 8'hA4, 4),  1'b1);

      // Address wrap at the top of the RAM
      wq.delete();
      do_start(12'hFF8);
      send_beat(8'h00, 1'b0, 5'd0);
      send_beat(8'h10, 1'b1, 5'd0);
      tick(4);
      check("wr_nwr", 128'(wq.size()), 128'(3));
      chk_wr("wr0", 0, 8'hFF, 16'h00FF, bytes_at(8, 8'h00, 8),  1'b0);
      chk_wr("wr1", 1, 8'h00, 16'hFFFF, bytes_at(0, 8'h08, 16), 1'b0);
      chk_wr("wr2", 2, 8'h01, 16'hFF00, bytes_at(0, 8'h18, 8),  1'b1);

      // Valid pulses in IDLE, then start together with valid
      wq.delete();
      i_VALID = 1'b1;
      tick(3);
      check("idle_ready", 128'(o_READY), 128'(0));
      i_VALID = 1'b0;
      for (int i = 0; i < 16; i++) din[i] = 8'hEE;
      i_VALID = 1'b1;
      do_start(12'h300);
      i_VALID = 1'b0;
      tick(3);
      check("idle_nwr", 128'(wq.size()), 128'(0));
      check("sv_busy",  128'(o_BUSY),    128'(1));
      send_beat(8'h50, 1'b1, 5'd0);
      tick(3);
      check("sv_nwr", 128'(wq.size()), 128'(1));
      chk_wr("sv0", 0, 8'h30, 16'hFFFF, bytes_at(0, 8'h50, 16), 1'b1);

      // Start during STREAM is ignored
      wq.delete();
      do_start(12'h100);
      send_beat(8'h30, 1'b0, 5'd0);
      do_start(12'h200);
      send_beat(8'h40, 1'b1, 5'd16);
      tick(4);
      check("ov_nwr", 128'(wq.size()), 128'(2));
      chk_wr("ov0", 0, 8'h10, 16'hFFFF, bytes_at(0, 8'h30, 16), 1'b0);
      chk_wr("ov1", 1, 8'h11, 16'hFFFF, bytes_at(0, 8'h40, 16), 1'b1);

      // Reset the cycle after the first beat is accepted
      wq.delete();
      do_start(12'h005);
      send_beat(8'h60, 1'b0, 5'd0);
      i_RST = 1'b1;
      #1;
      check("mr_we",    128'(o_WE),    128'(0));
      check("mr_ready", 128'(o_READY), 128'(0));
      check("mr_busy",  128'(o_BUSY),  128'(0));
      check("mr_wbe",   128'(o_WBE),   128'(0));
      check("mr_wdata", o_WDATA,       128'(0));
      check("mr_waddr", 128'(o_WADDR), 128'(0));
      tick(2);
      i_RST = 1'b0;
      for (int i = 0; i < 16; i++) din[i] = 8'h77;
      i_VALID = 1'b1;
      i_LAST  = 1'b1;
      tick(4);
      i_VALID = 1'b0;
      i_LAST  = 1'b0;
      check("mr_nwr", 128'(wq.size()), 128'(0));
      do_start(12'h020);
      send_beat(8'hC0, 1'b1, 5'd4);
      tick(3);
      check("mr2_nwr", 128'(wq.size()), 128'(1));
      chk_wr("mr2", 0, 8'h02, 16'hF000, bytes_at(0, 8'hC0, 4), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
